// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared definitions for the ID-stage branch controller: op codes, FSM
// encoding and the branch-target helper.
package br_pkg;

   localparam logic [2:0] BR_NONE = 3'b000;
   localparam logic [2:0] BR_BEQ  = 3'b001;
   localparam logic [2:0] BR_BNE  = 3'b010;
   localparam logic [2:0] BR_CBCL = 3'b011;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT    = 2'd1,
      ST_RESOLVE = 2'd2
   } br_state_e;

   // Target wraps modulo 2^32; no overflow is reported.
   function automatic logic [31:0] br_target(input logic [31:0] pc,
                                             input logic [15:0] imm);
      return pc + 32'd4 + {{14{imm[15]}}, imm, 2'b00};
   endfunction

endpackage

// File: rtl/branch_resolve_ctrl_cmp.sv
// Branch condition evaluator: decides whether the branch in ID would be
// taken from the forwarded operands.
module branch_cmp
   import br_pkg::*;
(
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic [2:0]  op,
   output logic        allow
);

   always_comb begin
      allow = 1'b0;
      case (op)
         BR_BEQ:  allow = (rs_val == rt_val);
         BR_BNE:  allow = (rs_val != rt_val);
         BR_CBCL: allow = rs_val[31];
         default: allow = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// ID-stage branch controller: load-use hazard hold, branch resolve and PC
// redirect, stall watchdog and debug counters.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  IDLE    | no branch held in ID (no-hazard branches resolve here)
//  WAIT    | branch held in ID waiting on an E/M producer
//  RESOLVE | held branch left ID last cycle
module branch_resolve_ctrl
   import br_pkg::*;
#(
   parameter int WDOG_MAX = 64,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             id_valid,
   input  logic [2:0]       id_br_op,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic [31:0]      rs_val,
   input  logic [31:0]      rt_val,
   input  logic [31:0]      id_pc,
   input  logic [15:0]      id_imm16,
   input  logic [4:0]       e_wa,
   input  logic [4:0]       m_wa,
   input  logic             e_rdy,
   input  logic             m_rdy,
   output logic             stall,
   output logic             redirect,
   output logic [31:0]      redirect_pc,
   output logic             wdog_err,
   output logic [CNT_W-1:0] taken_cnt,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam logic [7:0] WDOG_LIM = 8'(WDOG_MAX);

   br_state_e  state, state_nxt;
   logic [7:0] wait_cnt, wait_nxt;
   logic       use_rt, rs_hit, rt_hit, hz, cmp_allow;

   branch_cmp u_cmp (
      .rs_val (rs_val),
      .rt_val (rt_val),
      .op     (id_br_op),
      .allow  (cmp_allow)
   );

   assign use_rt = (id_br_op == BR_BEQ) || (id_br_op == BR_BNE);
   assign rs_hit = (id_rs != 5'd0) &&
                   (((id_rs == e_wa) && !e_rdy) || ((id_rs == m_wa) && !m_rdy));
   assign rt_hit = (id_rt != 5'd0) &&
                   (((id_rt == e_wa) && !e_rdy) || ((id_rt == m_wa) && !m_rdy));
   assign hz     = id_valid && (rs_hit || (use_rt && rt_hit));

   // Outputs are held low during reset so IF/ID never freeze on stale inputs.
   assign stall       = reset_n && hz && !flush;
   assign redirect    = reset_n && id_valid && !hz && !flush && cmp_allow;
   assign redirect_pc = br_target(id_pc, id_imm16);

   always_comb begin
      state_nxt = state;
      wait_nxt  = wait_cnt;
      case (state)
         ST_WAIT: begin
            if (!id_valid) begin
               state_nxt = ST_IDLE;
               wait_nxt  = 8'd0;
            end else if (!hz) begin
               state_nxt = ST_RESOLVE;
               wait_nxt  = 8'd0;
            end else if (wait_cnt != 8'hFF) begin
               wait_nxt = wait_cnt + 8'd1;
            end
         end
         default: begin
            if (hz) begin
               state_nxt = ST_WAIT;
               wait_nxt  = 8'd1;
            end else begin
               state_nxt = ST_IDLE;
               wait_nxt  = 8'd0;
            end
         end
      endcase
      if (flush) begin
         state_nxt = ST_IDLE;
         wait_nxt  = 8'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         wait_cnt  <= 8'd0;
         wdog_err  <= 1'b0;
         taken_cnt <= '0;
         stall_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_nxt;
         if ((state == ST_WAIT) && (wait_cnt == WDOG_LIM))
            wdog_err <= 1'b1;
         if (redirect)
            taken_cnt <= taken_cnt + 1'b1;
         if (stall)
            stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl; expected redirect targets are
// queued by the stimulus and consumed by a monitor whenever redirect is seen.
module tb_branch_resolve_ctrl;
   import br_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n, flush, id_valid, e_rdy, m_rdy;
   logic [2:0]  id_br_op;
   logic [4:0]  id_rs, id_rt, e_wa, m_wa;
   logic [31:0] rs_val, rt_val, id_pc, redirect_pc;
   logic [15:0] id_imm16;
   logic        stall, redirect, wdog_err;
   logic [31:0] taken_cnt, stall_cnt;

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_q[$];

   branch_resolve_ctrl #(.WDOG_MAX(4), .CNT_W(32)) dut (
      .clk(clk), .reset_n(reset_n), .flush(flush), .id_valid(id_valid),
      .id_br_op(id_br_op), .id_rs(id_rs), .id_rt(id_rt), .rs_val(rs_val),
      .rt_val(rt_val), .id_pc(id_pc), .id_imm16(id_imm16), .e_wa(e_wa),
      .m_wa(m_wa), .e_rdy(e_rdy), .m_rdy(m_rdy), .stall(stall),
      .redirect(redirect), .redirect_pc(redirect_pc), .wdog_err(wdog_err),
      .taken_cnt(taken_cnt), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: every observed redirect must match the oldest queued target.
   initial begin
      forever begin
         @(negedge clk);
         if (redirect === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_redirect: got pc 0x%08h expected no redirect", redirect_pc);
            end else begin
               chk("redirect_pc", redirect_pc, exp_q.pop_front());
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      flush = 0; id_valid = 0; id_br_op = BR_NONE; id_rs = 0; id_rt = 0;
      rs_val = 0; rt_val = 0; id_pc = 0; id_imm16 = 0;
      e_wa = 0; m_wa = 0; e_rdy = 1; m_rdy = 1;
   endtask

   task automatic br(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                     input logic [31:0] rv, input logic [31:0] tv,
                     input logic [31:0] pc, input logic [15:0] imm);
      id_valid = 1; id_br_op = op; id_rs = rs; id_rt = rt;
      rs_val = rv; rt_val = tv; id_pc = pc; id_imm16 = imm;
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   initial begin
      idle_in();
      reset_n = 0;
      // Hazarding, would-be-taken branch during reset: outputs must stay low.
      br(BR_BEQ, 5'd8, 5'd2, 32'd1, 32'd1, 32'h100, 16'h1);
      e_wa = 5'd8; e_rdy = 0;
      repeat (3) step();
      at_neg();
      chk("reset_stall", {31'd0, stall}, 32'd0);
      chk("reset_taken_cnt", taken_cnt, 32'd0);
      chk("reset_stall_cnt", stall_cnt, 32'd0);
      chk("reset_wdog", {31'd0, wdog_err}, 32'd0);
      step();
      reset_n = 1; idle_in();
      step();

      // beq taken, no hazard
      br(BR_BEQ, 5'd1, 5'd2, 32'd5, 32'd5, 32'h3000, 16'h0004);
      exp_q.push_back(32'h3014);
      at_neg();
      chk("beq_stall", {31'd0, stall}, 32'd0);
      step(); idle_in();
      at_neg();
      chk("beq_taken_cnt", taken_cnt, 32'd1);

      // bne with rs waiting on E for two cycles
      step();
      br(BR_BNE, 5'd8, 5'd3, 32'd1, 32'd2, 32'h100, 16'h0010);
      e_wa = 5'd8; e_rdy = 0;
      at_neg(); chk("bne_stall_c0", {31'd0, stall}, 32'd1);
      step();
      at_neg(); chk("bne_stall_c1", {31'd0, stall}, 32'd1);
      step();
      e_rdy = 1;
      exp_q.push_back(32'h144);
      at_neg(); chk("bne_stall_c2", {31'd0, stall}, 32'd0);
      step(); idle_in();
      at_neg();
      chk("bne_stall_cnt", stall_cnt, 32'd2);
      chk("bne_taken_cnt", taken_cnt, 32'd2);

      // cbcl ignores rt hazard
      step();
      br(BR_CBCL, 5'd1, 5'd9, 32'h8000_0000, 32'd0, 32'h2000, 16'hFFFF);
      m_wa = 5'd9; m_rdy = 0;
      exp_q.push_back(32'h2000);
      at_neg(); chk("cbcl_stall", {31'd0, stall}, 32'd0);
      step(); idle_in();

      // target wrap-around, positive and negative offsets
      br(BR_BEQ, 5'd1, 5'd2, 32'd7, 32'd7, 32'hFFFF_FFF0, 16'h7FFF);
      exp_q.push_back(32'h0001_FFF0);
      step();
      br(BR_BEQ, 5'd1, 5'd2, 32'd7, 32'd7, 32'hFFFF_FFF0, 16'h8000);
      exp_q.push_back(32'hFFFD_FFF4);
      step(); idle_in();
      at_neg(); chk("wrap_taken_cnt", taken_cnt, 32'd5);

      // not-taken cases: beq unequal, cbcl non-negative, reserved op
      step();
      br(BR_BEQ, 5'd1, 5'd2, 32'd1, 32'd2, 32'h40, 16'h1);
      step();
      br(BR_CBCL, 5'd1, 5'd2, 32'h7FFF_FFFF, 32'd0, 32'h40, 16'h1);
      step();
      br(3'b100, 5'd1, 5'd2, 32'd3, 32'd3, 32'h40, 16'h1);
      step(); idle_in();
      at_neg(); chk("nt_taken_cnt", taken_cnt, 32'd5);

      // watchdog: rt hazard on M held 6 cycles, WDOG_MAX=4
      step();
      br(BR_BEQ, 5'd1, 5'd3, 32'd1, 32'd2, 32'h80, 16'h1);
      m_wa = 5'd3; m_rdy = 0;
      for (int i = 0; i < 6; i++) begin
         at_neg();
         if (i == 4) chk("wdog_before", {31'd0, wdog_err}, 32'd0);
         if (i == 5) chk("wdog_set", {31'd0, wdog_err}, 32'd1);
         step();
      end
      m_rdy = 1;
      at_neg(); chk("wdog_resolve_stall", {31'd0, stall}, 32'd0);
      step(); idle_in();
      at_neg();
      chk("wdog_sticky", {31'd0, wdog_err}, 32'd1);
      chk("wdog_stall_cnt", stall_cnt, 32'd8);

      // flush during WAIT with a would-be-taken branch
      step();
      br(BR_BNE, 5'd8, 5'd3, 32'd1, 32'd2, 32'h500, 16'h2);
      e_wa = 5'd8; e_rdy = 0;
      step(); step();
      flush = 1;
      at_neg(); chk("flush_stall", {31'd0, stall}, 32'd0);
      step(); idle_in();
      at_neg();
      chk("flush_stall_cnt", stall_cnt, 32'd10);
      chk("flush_taken_cnt", taken_cnt, 32'd5);

      // reset during WAIT drops branch and clears counters
      step();
      br(BR_BNE, 5'd8, 5'd3, 32'd1, 32'd2, 32'h600, 16'h2);
      e_wa = 5'd8; e_rdy = 0;
      step(); step();
      reset_n = 0;
      at_neg(); chk("rst_wait_stall", {31'd0, stall}, 32'd0);
      step();
      at_neg();
      chk("rst_wait_taken_cnt", taken_cnt, 32'd0);
      chk("rst_wait_stall_cnt", stall_cnt, 32'd0);
      chk("rst_wait_wdog", {31'd0, wdog_err}, 32'd0);
      step();
      reset_n = 1; idle_in();
      step();
      at_neg(); chk("post_rst_stall", {31'd0, stall}, 32'd0);

      step(); step();
      chk("pending_redirects", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
